// File: rtl/cdc_req_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_req_arbiter_if
//  Description : Bundle of requester-side and far-domain handshake signals
//                for cdc_req_arbiter. The arbiter uses the slave modport; the
//                environment driving requesters and the far domain uses master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdc_req_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_done;
  logic               cdc_req;
  logic [DW-1:0]      cdc_data;
  logic               cdc_ack;
  logic [c_IW-1:0]    grant_id;
  logic               busy;
  logic               err_flag;
  logic               err_clr;

  modport slave (
    input  req_valid, req_data, cdc_ack, err_clr,
    output req_done, cdc_req, cdc_data, grant_id, busy, err_flag
  );

  modport master (
    output req_valid, req_data, cdc_ack, err_clr,
    input  req_done, cdc_req, cdc_data, grant_id, busy, err_flag
  );
endinterface
`default_nettype wire

// File: rtl/cdc_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_req_arbiter
//  Description : Round-robin arbiter that shares one 4-phase req/ack channel
//                into an asynchronous domain among NREQ requesters. The ack
//                is synchronized before use, waiting for ack high is bounded
//                by TIMEOUT cycles, and a timeout raises a sticky err_flag.
//                NREQ and DW must match the parameters of the bus interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  cdc_req_arbiter_if.slave    bus
);

  localparam int              c_IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              c_CW  = 16;
  localparam logic [c_CW-1:0] c_TMO = c_CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_REL   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic [c_CW-1:0]        cnt_q;
  logic [c_CW-1:0]        cnt_inc;
  logic [c_IW-1:0]        last_grant_q;
  logic [c_IW-1:0]        grant_id_q;
  logic                   cdc_req_q;
  logic [DW-1:0]          cdc_data_q;
  logic [NREQ-1:0]        req_done_q;
  logic                   busy_q;
  logic                   err_flag_q;
  logic [c_IW-1:0]        pick_d;
  logic                   pick_vld_d;

  // Index of the k-th requester after base, wrapping at NREQ (k <= NREQ).
  function automatic logic [c_IW-1:0] rr_idx(input logic [c_IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return c_IW'(s);
  endfunction

  // Bring the far-domain ack into clk; only the last stage feeds the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.cdc_ack};
  end

  assign ack_s   = ack_sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + 1'b1;

  // Round-robin pick: scan from the requester after the last grant; the
  // loop runs farthest-first so the nearest pending requester wins.
  always_comb begin
    pick_d     = '0;
    pick_vld_d = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_valid[rr_idx(last_grant_q, k)]) begin
        pick_d     = rr_idx(last_grant_q, k);
        pick_vld_d = 1'b1;
      end
    end
  end

  // Handshake FSM with every output registered; err_clr is applied before
  // the state actions so a same-cycle timeout set overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= c_IW'(NREQ - 1);
      grant_id_q   <= '0;
      cdc_req_q    <= 1'b0;
      cdc_data_q   <= '0;
      req_done_q   <= '0;
      busy_q       <= 1'b0;
      err_flag_q   <= 1'b0;
    end else begin
      req_done_q <= '0;
      if (bus.err_clr) err_flag_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          // A stale high ack is irrelevant here; it is only looked at in REQ.
          if (pick_vld_d) begin
            state_q      <= S_REQ;
            cdc_req_q    <= 1'b1;
            cdc_data_q   <= bus.req_data[int'(pick_d)*DW +: DW];
            grant_id_q   <= pick_d;
            last_grant_q <= pick_d;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
          end
        end
        S_REQ: begin
          if (ack_s) begin
            state_q   <= S_REL;
            cdc_req_q <= 1'b0;
            cnt_q     <= '0;
          end else if (cnt_inc == c_TMO) begin
            state_q    <= S_ABORT;
            cdc_req_q  <= 1'b0;
            cnt_q      <= '0;
            err_flag_q <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        S_REL: begin
          if (!ack_s) begin
            state_q                <= S_DONE;
            req_done_q[grant_id_q] <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_ABORT: begin
          // Wait out a late ack so the far side sees a complete return to zero.
          if (!ack_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          cdc_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cdc_req  = cdc_req_q;
  assign bus.cdc_data = cdc_data_q;
  assign bus.req_done = req_done_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.err_flag = err_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_req_arbiter
//  Description : Self-checking bench for cdc_req_arbiter. A far-domain agent
//                answers the 4-phase handshake; expected grants come from a
//                rotating-priority model of the pending requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_req_arbiter;

  localparam int NREQ        = 4;
  localparam int DW          = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cdc_req_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  cdc_req_arbiter #(
    .NREQ        (NREQ),
    .DW          (DW),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int m_last = NREQ - 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Nearest pending requester after the previous winner, in rotational order.
  function automatic int rr_expect(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.cdc_ack   = 1'b0;
    bus.err_clr   = 1'b0;
    repeat (2) tick();
    rst_n  = 1'b1;
    m_last = NREQ - 1;
  endtask

  // One complete transfer; the caller has set req_valid with the DUT idle.
  task automatic xfer(input string tag, input int d, input bit drop);
    int              exp_id;
    logic [DW-1:0]   exp_data;
    int              n;
    bit              bad;
    exp_id   = rr_expect(bus.req_valid, m_last);
    exp_data = bus.req_data[exp_id*DW +: DW];
    bad      = 1'b0;
    n        = 0;
    do begin tick(); n++; end while (bus.cdc_req !== 1'b1 && n < 4);
    chk({tag, "/grant_lat"}, n, 1);
    chk({tag, "/grant_id"}, bus.grant_id, exp_id);
    chk({tag, "/cdc_data"}, bus.cdc_data, exp_data);
    chk({tag, "/busy_req"}, bus.busy, 1);
    m_last       = exp_id;
    bus.req_data = $urandom;
    for (int i = 0; i < d; i++) begin
      tick();
      if (drop && i == 0) bus.req_valid[exp_id] = 1'b0;
      if (bus.cdc_req !== 1'b1 || bus.cdc_data !== exp_data || bus.req_done !== '0) bad = 1'b1;
    end
    bus.cdc_ack = 1'b1;
    n = 0;
    while (bus.cdc_req === 1'b1 && n < 20) begin
      tick(); n++;
      if (bus.cdc_data !== exp_data || bus.req_done !== '0) bad = 1'b1;
    end
    chk({tag, "/req_to_rel"}, n, SYNC_STAGES + 1);
    chk({tag, "/busy_rel"}, bus.busy, 1);
    bus.cdc_ack = 1'b0;
    n = 0;
    while (bus.req_done === '0 && n < 20) begin
      tick(); n++;
      if (bus.cdc_data !== exp_data || bus.cdc_req !== 1'b0) bad = 1'b1;
    end
    chk({tag, "/rel_to_done"}, n, SYNC_STAGES + 1);
    chk({tag, "/req_done"}, bus.req_done, 64'd1 << exp_id);
    tick();
    chk({tag, "/done_1cyc"}, bus.req_done, 0);
    chk({tag, "/busy_idle"}, bus.busy, 0);
    chk({tag, "/stable"}, bad, 0);
  endtask

  // Transfer that is never acknowledged; optionally holds err_clr high.
  task automatic tmo(input string tag, input bit clr_hold);
    int exp_id;
    int n;
    bit bad;
    exp_id      = rr_expect(bus.req_valid, m_last);
    bus.err_clr = clr_hold;
    bad         = 1'b0;
    n           = 0;
    do begin tick(); n++; end while (bus.cdc_req !== 1'b1 && n < 4);
    chk({tag, "/grant_lat"}, n, 1);
    chk({tag, "/grant_id"}, bus.grant_id, exp_id);
    m_last = exp_id;
    n = 0;
    while (bus.cdc_req === 1'b1 && n < 40) begin
      if (bus.req_done !== '0) bad = 1'b1;
      tick(); n++;
    end
    chk({tag, "/req_cycles"}, n, TIMEOUT);
    chk({tag, "/err_set"}, bus.err_flag, 1);
    chk({tag, "/busy_abort"}, bus.busy, 1);
    bus.req_valid = '0;
    tick();
    if (bus.req_done !== '0) bad = 1'b1;
    chk({tag, "/busy_idle"}, bus.busy, 0);
    if (clr_hold) begin
      chk({tag, "/err_cleared"}, bus.err_flag, 0);
    end else begin
      repeat (3) tick();
      chk({tag, "/err_sticky"}, bus.err_flag, 1);
      bus.err_clr = 1'b1;
      tick();
      chk({tag, "/err_clr"}, bus.err_flag, 0);
    end
    bus.err_clr = 1'b0;
    chk({tag, "/no_done"}, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    logic [NREQ-1:0] mask;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.cdc_ack   = 1'b0;
    bus.err_clr   = 1'b0;
    repeat (2) tick();
    chk("rst/cdc_req",  bus.cdc_req,  0);
    chk("rst/cdc_data", bus.cdc_data, 0);
    chk("rst/req_done", bus.req_done, 0);
    chk("rst/grant_id", bus.grant_id, 0);
    chk("rst/busy",     bus.busy,     0);
    chk("rst/err_flag", bus.err_flag, 0);
    rst_n = 1'b1;
    tick();

    // Single requester, ack three cycles after cdc_req.
    bus.req_data  = {24'h123456, 8'hA5};
    bus.req_valid = 4'b0001;
    xfer("single", 3, 1'b0);
    bus.req_valid = '0;
    tick();

    // All requesters held: strict rotation 0,1,2,3,0 from reset.
    do_reset();
    bus.req_data  = 32'h44332211;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      chk("rr/order", rr_expect(bus.req_valid, m_last), i % NREQ);
      xfer("rr", 1, 1'b0);
    end
    bus.req_valid = '0;
    tick();

    // Timeout with sticky error, then the aborted requester yields priority.
    bus.req_valid = 4'b0001;
    tmo("tmo", 1'b0);
    bus.req_valid = 4'b0011;
    xfer("after_abort", 2, 1'b0);
    bus.req_valid = '0;
    tick();

    // Timeout coinciding with a held err_clr: the set must win.
    bus.req_valid = 4'b0100;
    tmo("tmo_clr", 1'b1);
    tick();

    // Ack already high before any grant.
    bus.cdc_ack = 1'b1;
    repeat (4) tick();
    chk("ackpre/idle_req",  bus.cdc_req, 0);
    chk("ackpre/idle_busy", bus.busy,    0);
    bus.req_valid = 4'b1000;
    tick();
    chk("ackpre/req_rise", bus.cdc_req,  1);
    chk("ackpre/grant_id", bus.grant_id, rr_expect(4'b1000, m_last));
    m_last        = 3;
    bus.req_valid = '0;
    tick();
    chk("ackpre/rel",      bus.cdc_req, 0);
    chk("ackpre/busy_rel", bus.busy,    1);
    bus.cdc_ack = 1'b0;
    n = 0;
    while (bus.req_done === '0 && n < 20) begin tick(); n++; end
    chk("ackpre/rel_to_done", n, SYNC_STAGES + 1);
    chk("ackpre/req_done", bus.req_done, 4'b1000);
    tick();
    chk("ackpre/busy_idle", bus.busy, 0);

    // Requester 2 withdraws one cycle after its grant.
    bus.req_valid = 4'b0100;
    xfer("drop2", 3, 1'b1);
    chk("drop2/valid_gone", bus.req_valid, 0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      mask          = 4'($urandom_range(1, 15));
      bus.req_data  = $urandom;
      bus.req_valid = mask;
      xfer("rand", int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
    end
    bus.req_valid = '0;
    tick();

    // Reset while in the release phase.
    bus.req_valid = 4'b0010;
    tick();
    chk("rstrel/req", bus.cdc_req, 1);
    bus.cdc_ack   = 1'b1;
    bus.req_valid = '0;
    n = 0;
    while (bus.cdc_req === 1'b1 && n < 20) begin tick(); n++; end
    chk("rstrel/in_rel", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstrel/cdc_req",  bus.cdc_req,  0);
    chk("rstrel/busy",     bus.busy,     0);
    chk("rstrel/req_done", bus.req_done, 0);
    chk("rstrel/grant_id", bus.grant_id, 0);
    chk("rstrel/cdc_data", bus.cdc_data, 0);
    chk("rstrel/err_flag", bus.err_flag, 0);
    bus.cdc_ack = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (bus.req_done !== '0 || bus.cdc_req !== 1'b0) bad = 1'b1;
    end
    chk("rstrel/quiet", bad, 0);
    rst_n  = 1'b1;
    m_last = NREQ - 1;
    tick();
    bus.req_valid = 4'b1111;
    xfer("post_rst", 2, 1'b0);
    bus.req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
